// File: rtl/videocard_pkg.sv
// rtl/videocard_pkg.sv - shared dispatcher state encoding and default sizing
package videocard_pkg;

   localparam int DEF_CORE_NUM  = 4;
   localparam int DEF_INT_NUM   = 3;
   localparam int DEF_TIMEOUT_W = 16;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE   = 2'd0;
   localparam state_t ST_LAUNCH = 2'd1;
   localparam state_t ST_WAIT   = 2'd2;
   localparam state_t ST_FINISH = 2'd3;

endpackage

// File: rtl/dispatch_watchdog.sv
// rtl/dispatch_watchdog.sv - wrapping cycle counter with limit compare for the WAIT watchdog
module dispatch_watchdog #(
   parameter int TIMEOUT_W = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 i_clear,
   input  logic                 i_enable,
   input  logic [TIMEOUT_W-1:0] i_limit,
   output logic                 o_expire
);

   logic [TIMEOUT_W-1:0] r_count;
   logic [TIMEOUT_W-1:0] w_count_inc;

   assign w_count_inc = r_count + TIMEOUT_W'(1);

   // Expiry looks one count ahead so the job ends after exactly i_limit enabled cycles.
   assign o_expire = (i_limit != '0) && (w_count_inc == i_limit);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_enable) begin
         r_count <= w_count_inc;
      end
   end

endmodule

// File: rtl/job_dispatcher.sv
// rtl/job_dispatcher.sv - launches a job on enabled shader cores and collects completion
module job_dispatcher
   import videocard_pkg::*;
#(
   parameter int CORE_NUM  = DEF_CORE_NUM,
   parameter int INT_NUM   = DEF_INT_NUM,
   parameter int TIMEOUT_W = DEF_TIMEOUT_W
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 start,
   input  logic [INT_NUM-1:0]   int_num_in,
   input  logic [CORE_NUM-1:0]  core_en,
   input  logic [TIMEOUT_W-1:0] timeout_limit,
   input  logic [CORE_NUM-1:0]  core_done,
   output logic [CORE_NUM-1:0]  core_start,
   output logic [INT_NUM-1:0]   core_int_num,
   output logic                 busy,
   output logic                 finish,
   output logic                 timed_out,
   output logic [CORE_NUM-1:0]  done_mask,
   output logic                 overrun
);

   state_t                r_state;
   logic [CORE_NUM-1:0]   r_en_mask;
   logic                  r_pend_valid;
   logic [CORE_NUM-1:0]   r_pend_en;
   logic [INT_NUM-1:0]    r_pend_job;

   logic [CORE_NUM-1:0]   r_core_start;
   logic [INT_NUM-1:0]    r_core_int_num;
   logic                  r_busy;
   logic                  r_finish;
   logic                  r_timed_out;
   logic [CORE_NUM-1:0]   r_done_mask;
   logic                  r_overrun;

   state_t                w_next_state;
   logic [CORE_NUM-1:0]   w_nxt_mask;
   logic                  w_launch;
   logic [CORE_NUM-1:0]   w_launch_en;
   logic [INT_NUM-1:0]    w_launch_job;
   logic                  w_empty;
   logic                  w_timeout;
   logic                  w_pend_req;
   logic                  w_pend_take;
   logic                  w_expire;

   dispatch_watchdog #(
      .TIMEOUT_W (TIMEOUT_W)
   ) u_watchdog (
      .clk      (clk),
      .reset_n  (reset_n),
      .i_clear  (r_state == ST_LAUNCH),
      .i_enable (r_state == ST_WAIT),
      .i_limit  (timeout_limit),
      .o_expire (w_expire)
   );

   assign w_nxt_mask = r_done_mask | (core_done & r_en_mask);
   assign w_pend_req = start && (r_state != ST_IDLE);

   always_comb begin
      w_next_state = r_state;
      w_launch     = 1'b0;
      w_launch_en  = '0;
      w_launch_job = '0;
      w_empty      = 1'b0;
      w_timeout    = 1'b0;
      w_pend_take  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               if (core_en != '0) begin
                  w_next_state = ST_LAUNCH;
                  w_launch     = 1'b1;
                  w_launch_en  = core_en;
                  w_launch_job = int_num_in;
               end else begin
                  w_next_state = ST_FINISH;
                  w_empty      = 1'b1;
               end
            end
         end
         ST_LAUNCH: begin
            w_next_state = ST_WAIT;
         end
         ST_WAIT: begin
            // Completion is checked first so it wins over a simultaneous expiry.
            if (w_nxt_mask == r_en_mask) begin
               w_next_state = ST_FINISH;
            end else if (w_expire) begin
               w_next_state = ST_FINISH;
               w_timeout    = 1'b1;
            end
         end
         default: begin
            if (r_pend_valid) begin
               w_pend_take = 1'b1;
               if (r_pend_en != '0) begin
                  w_next_state = ST_LAUNCH;
                  w_launch     = 1'b1;
                  w_launch_en  = r_pend_en;
                  w_launch_job = r_pend_job;
               end else begin
                  w_next_state = ST_FINISH;
                  w_empty      = 1'b1;
               end
            end else begin
               w_next_state = ST_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state        <= ST_IDLE;
         r_en_mask      <= '0;
         r_pend_valid   <= 1'b0;
         r_pend_en      <= '0;
         r_pend_job     <= '0;
         r_core_start   <= '0;
         r_core_int_num <= '0;
         r_busy         <= 1'b0;
         r_finish       <= 1'b0;
         r_timed_out    <= 1'b0;
         r_done_mask    <= '0;
         r_overrun      <= 1'b0;
      end else begin
         r_state      <= w_next_state;
         r_busy       <= (w_next_state != ST_IDLE);
         r_finish     <= (w_next_state == ST_FINISH);
         r_timed_out  <= w_timeout;
         r_core_start <= w_launch ? w_launch_en : '0;
         r_overrun    <= w_pend_req && r_pend_valid;

         if (w_launch) begin
            r_en_mask      <= w_launch_en;
            r_core_int_num <= w_launch_job;
            r_done_mask    <= '0;
         end else if (w_empty) begin
            r_done_mask    <= '0;
         end else if (r_state == ST_WAIT) begin
            r_done_mask    <= w_nxt_mask;
         end

         // A full slot is only ever freed by FINISH, so store and take never coincide.
         if (w_pend_req && !r_pend_valid) begin
            r_pend_valid <= 1'b1;
            r_pend_en    <= core_en;
            r_pend_job   <= int_num_in;
         end else if (w_pend_take) begin
            r_pend_valid <= 1'b0;
         end
      end
   end

   assign core_start   = r_core_start;
   assign core_int_num = r_core_int_num;
   assign busy         = r_busy;
   assign finish       = r_finish;
   assign timed_out    = r_timed_out;
   assign done_mask    = r_done_mask;
   assign overrun      = r_overrun;

endmodule

// File: tb/tb_job_dispatcher.sv
// tb/tb_job_dispatcher.sv - directed self-checking bench for job_dispatcher
module tb_job_dispatcher;

   logic        clk;
   logic        reset_n;
   logic        start;
   logic [2:0]  int_num_in;
   logic [3:0]  core_en;
   logic [15:0] timeout_limit;
   logic [3:0]  core_done;
   logic [3:0]  core_start;
   logic [2:0]  core_int_num;
   logic        busy;
   logic        finish;
   logic        timed_out;
   logic [3:0]  done_mask;
   logic        overrun;

   int checks = 0;
   int errors = 0;

   job_dispatcher dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .start         (start),
      .int_num_in    (int_num_in),
      .core_en       (core_en),
      .timeout_limit (timeout_limit),
      .core_done     (core_done),
      .core_start    (core_start),
      .core_int_num  (core_int_num),
      .busy          (busy),
      .finish        (finish),
      .timed_out     (timed_out),
      .done_mask     (done_mask),
      .overrun       (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      tick();
      tick();
      checks++; if (core_start !== 4'b0000) begin errors++; $display("FAIL rst_core_start: got %b exp 0000", core_start); end
      checks++; if (busy !== 1'b0 || finish !== 1'b0 || timed_out !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL rst_flags: got busy=%b fin=%b to=%b ovr=%b exp all 0", busy, finish, timed_out, overrun); end
      checks++; if (done_mask !== 4'b0000 || core_int_num !== 3'd0) begin errors++; $display("FAIL rst_masks: got dm=%b int=%0d exp 0000/0", done_mask, core_int_num); end
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_all_cores;
      start = 1'b1; int_num_in = 3'd5; core_en = 4'b1111; timeout_limit = 16'd0;
      tick();
      start = 1'b0;
      checks++; if (core_start !== 4'b1111) begin errors++; $display("FAIL all_core_start: got %b exp 1111", core_start); end
      checks++; if (core_int_num !== 3'd5) begin errors++; $display("FAIL all_int_num: got %0d exp 5", core_int_num); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL all_busy: got %b exp 1", busy); end
      tick();
      checks++; if (core_start !== 4'b0000) begin errors++; $display("FAIL all_start_pulse: got %b exp 0000", core_start); end
      core_done = 4'b0001; tick();
      core_done = 4'b0010; tick();
      core_done = 4'b0100; tick();
      checks++; if (finish !== 1'b0 || done_mask !== 4'b0111) begin errors++; $display("FAIL all_partial: got fin=%b dm=%b exp 0/0111", finish, done_mask); end
      core_done = 4'b1000; tick();
      core_done = 4'b0000;
      checks++; if (finish !== 1'b1 || timed_out !== 1'b0) begin errors++; $display("FAIL all_finish: got fin=%b to=%b exp 1/0", finish, timed_out); end
      checks++; if (done_mask !== 4'b1111) begin errors++; $display("FAIL all_done_mask: got %b exp 1111", done_mask); end
      tick();
      checks++; if (finish !== 1'b0 || busy !== 1'b0 || done_mask !== 4'b1111) begin errors++; $display("FAIL all_idle: got fin=%b busy=%b dm=%b exp 0/0/1111", finish, busy, done_mask); end
   endtask

   task automatic test_mask_filter;
      start = 1'b1; int_num_in = 3'd1; core_en = 4'b0101; timeout_limit = 16'd0;
      tick();
      start = 1'b0;
      tick();
      core_done = 4'b1010; tick();
      checks++; if (finish !== 1'b0 || done_mask !== 4'b0000) begin errors++; $display("FAIL mask_ignore: got fin=%b dm=%b exp 0/0000", finish, done_mask); end
      core_done = 4'b0101; tick();
      core_done = 4'b0000;
      checks++; if (finish !== 1'b1 || done_mask !== 4'b0101 || timed_out !== 1'b0) begin errors++; $display("FAIL mask_finish: got fin=%b dm=%b to=%b exp 1/0101/0", finish, done_mask, timed_out); end
      tick();
   endtask

   task automatic test_timeout;
      int early;
      start = 1'b1; int_num_in = 3'd3; core_en = 4'b1111; timeout_limit = 16'd10;
      tick();
      start = 1'b0;
      tick();
      core_done = 4'b0011; tick();
      core_done = 4'b0000;
      early = 0;
      for (int i = 0; i < 8; i++) begin
         if (finish !== 1'b0) early++;
         tick();
      end
      checks++; if (early != 0 || finish !== 1'b0) begin errors++; $display("FAIL to_early: got %0d early finish cycles exp 0", early + int'(finish)); end
      tick();
      checks++; if (finish !== 1'b1 || timed_out !== 1'b1) begin errors++; $display("FAIL to_expire: got fin=%b to=%b exp 1/1", finish, timed_out); end
      checks++; if (done_mask !== 4'b0011) begin errors++; $display("FAIL to_done_mask: got %b exp 0011", done_mask); end
      tick();
      // Last done lands on the expiry cycle: completion wins.
      start = 1'b1; int_num_in = 3'd4; core_en = 4'b0011; timeout_limit = 16'd10;
      tick();
      start = 1'b0;
      tick();
      core_done = 4'b0001; tick();
      core_done = 4'b0000;
      for (int i = 0; i < 8; i++) tick();
      checks++; if (finish !== 1'b0) begin errors++; $display("FAIL to_race_early: got fin=%b exp 0", finish); end
      core_done = 4'b0010; tick();
      core_done = 4'b0000;
      checks++; if (finish !== 1'b1 || timed_out !== 1'b0 || done_mask !== 4'b0011) begin errors++; $display("FAIL to_race: got fin=%b to=%b dm=%b exp 1/0/0011", finish, timed_out, done_mask); end
      tick();
      timeout_limit = 16'd0;
   endtask

   task automatic test_back_to_back;
      start = 1'b1; int_num_in = 3'd6; core_en = 4'b1111;
      tick();
      int_num_in = 3'd2; core_en = 4'b0001;
      tick();
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_queue: got ovr=%b exp 0", overrun); end
      int_num_in = 3'd3; core_en = 4'b0010;
      tick();
      start = 1'b0;
      checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL b2b_overrun: got ovr=%b exp 1", overrun); end
      tick();
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_ovr_pulse: got ovr=%b exp 0", overrun); end
      core_done = 4'b1111; tick();
      core_done = 4'b0000;
      checks++; if (finish !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL b2b_finish1: got fin=%b busy=%b exp 1/1", finish, busy); end
      tick();
      checks++; if (core_start !== 4'b0001 || core_int_num !== 3'd2 || busy !== 1'b1 || finish !== 1'b0) begin errors++; $display("FAIL b2b_launch2: got cs=%b int=%0d busy=%b fin=%b exp 0001/2/1/0", core_start, core_int_num, busy, finish); end
      tick();
      core_done = 4'b0001; tick();
      core_done = 4'b0000;
      checks++; if (finish !== 1'b1 || done_mask !== 4'b0001) begin errors++; $display("FAIL b2b_finish2: got fin=%b dm=%b exp 1/0001", finish, done_mask); end
      tick();
      tick();
      checks++; if (busy !== 1'b0 || core_start !== 4'b0000) begin errors++; $display("FAIL b2b_dropped: got busy=%b cs=%b exp 0/0000", busy, core_start); end
   endtask

   task automatic test_empty_job;
      start = 1'b1; int_num_in = 3'd7; core_en = 4'b0000;
      tick();
      start = 1'b0;
      checks++; if (finish !== 1'b1 || done_mask !== 4'b0000 || core_start !== 4'b0000) begin errors++; $display("FAIL empty_finish: got fin=%b dm=%b cs=%b exp 1/0000/0000", finish, done_mask, core_start); end
      checks++; if (core_int_num !== 3'd2) begin errors++; $display("FAIL empty_int_held: got %0d exp 2", core_int_num); end
      tick();
      checks++; if (finish !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL empty_idle: got fin=%b busy=%b exp 0/0", finish, busy); end
      // Empty job queued behind a real one: FINISH then FINISH again.
      start = 1'b1; int_num_in = 3'd1; core_en = 4'b0001;
      tick();
      core_en = 4'b0000;
      tick();
      start = 1'b0;
      core_done = 4'b0001; tick();
      core_done = 4'b0000;
      checks++; if (finish !== 1'b1 || done_mask !== 4'b0001) begin errors++; $display("FAIL empty_pend_f1: got fin=%b dm=%b exp 1/0001", finish, done_mask); end
      tick();
      checks++; if (finish !== 1'b1 || done_mask !== 4'b0000 || core_start !== 4'b0000) begin errors++; $display("FAIL empty_pend_f2: got fin=%b dm=%b cs=%b exp 1/0000/0000", finish, done_mask, core_start); end
      tick();
      checks++; if (finish !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL empty_pend_idle: got fin=%b busy=%b exp 0/0", finish, busy); end
   endtask

   task automatic test_reset_mid_job;
      int bad;
      start = 1'b1; int_num_in = 3'd4; core_en = 4'b1111;
      tick();
      int_num_in = 3'd1; core_en = 4'b0011;
      tick();
      start = 1'b0;
      core_done = 4'b0001; tick();
      reset_n = 1'b0;
      #2;
      checks++; if (busy !== 1'b0 || done_mask !== 4'b0000 || core_int_num !== 3'd0 || core_start !== 4'b0000) begin errors++; $display("FAIL midrst_async: got busy=%b dm=%b int=%0d cs=%b exp 0/0000/0/0000", busy, done_mask, core_int_num, core_start); end
      tick();
      reset_n = 1'b1;
      core_done = 4'b0000;
      bad = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (finish !== 1'b0 || core_start !== 4'b0000 || busy !== 1'b0) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL midrst_quiet: got %0d active cycles exp 0", bad); end
   endtask

   initial begin
      reset_n = 1'b0; start = 1'b0; int_num_in = '0; core_en = '0;
      timeout_limit = '0; core_done = '0;
      test_reset();
      test_all_cores();
      test_mask_filter();
      test_timeout();
      test_back_to_back();
      test_empty_job();
      test_reset_mid_job();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/job_dispatcher.md
# job_dispatcher

Sequences a render job across the videocard's shader cores. It latches a host job request (interrupt number plus core-enable mask) and issues a one-cycle start pulse to every enabled core. It then collects per-core completion and raises a single finish pulse with a completion mask once all enabled cores are done or a watchdog expires. It sits between the host interrupt line and the core array, and replaces the direct fan-out of the start interrupt and the OR-style finish collection.

## Interface
Parameters:
- CORE_NUM, 4, number of cores managed
- INT_NUM, 3, width of the interrupt/job number
- TIMEOUT_W, 16, width of the watchdog counter and limit

Ports:
- clk  in  1  system clock, all logic rising-edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  job request pulse from host; sampled each cycle
- int_num_in  in  INT_NUM  job number, sampled with start
- core_en  in  CORE_NUM  enabled-core mask, sampled with start
- timeout_limit  in  TIMEOUT_W  watchdog limit in WAIT cycles; 0 disables watchdog
- core_done  in  CORE_NUM  per-core completion pulse/level
- core_start  out  CORE_NUM  one-cycle start pulse per enabled core
- core_int_num  out  INT_NUM  job number to cores, held from LAUNCH until next launch
- busy  out  1  high in every state except IDLE
- finish  out  1  one-cycle job-complete pulse
- timed_out  out  1  qualifies finish: job ended by watchdog
- done_mask  out  CORE_NUM  cores that reported done in current/last job; valid with finish, held until next LAUNCH
- overrun  out  1  one-cycle pulse: start dropped because pending slot full

## Operation
- All outputs are registered. Reset value of every output is 0. Internal state resets to IDLE, pending=0, timer=0.
- States: IDLE, LAUNCH, WAIT, FINISH.
- IDLE:
  - start with core_en!=0: latch en_mask=core_en and job=int_num_in, then go to LAUNCH.
  - start with core_en==0: set done_mask=0, then go directly to FINISH (empty job, no core_start).
- LAUNCH: core_start=en_mask, core_int_num=job, done_mask=0, timer=0. Go to WAIT. core_done is ignored here and in IDLE.
- WAIT:
  - nxt = done_mask | (core_done & en_mask). done_mask <= nxt.
  - timer increments by 1 each cycle and wraps modulo 2^TIMEOUT_W.
  - If nxt==en_mask, go to FINISH with timed_out=0.
  - Else if timeout_limit!=0 and timer+1==timeout_limit, go to FINISH with timed_out=1.
  - If completion and timeout occur in the same cycle, completion wins (timed_out=0).
- FINISH: finish=1 (timed_out as decided) for exactly one cycle.
  - If pending is set, go to LAUNCH with the pending job and clear pending.
  - Otherwise go to IDLE.
- Pending slot, 1 deep: start while busy stores {core_en, int_num_in} if pending is empty. If pending is full, the request is dropped and overrun pulses.
  - A pending job with core_en==0 goes FINISH→FINISH: a second finish pulse with done_mask=0.
- core_done bits outside en_mask never affect done_mask.
- Reset asserted mid-job: everything returns immediately to reset values. The pending job is lost, no finish is issued, and core_start drops asynchronously.

## Timing
- start sampled at edge N → core_start high in cycle N+1 (LAUNCH) → WAIT from N+2.
- Last core_done sampled at edge M in WAIT → finish high in cycle M+1.
- Minimum start-to-finish is 3 cycles (all cores done in first WAIT cycle). An empty job takes 1 cycle.
- Watchdog: finish with timed_out arrives exactly timeout_limit WAIT cycles after entering WAIT.
- Back-to-back: with pending set, LAUNCH follows FINISH with no IDLE cycle. busy stays high throughout.
- A start in the FINISH cycle is treated as busy-time (goes to pending).

## Structure
- Shared package (videocard_pkg): state enum {IDLE, LAUNCH, WAIT, FINISH} and default CORE_NUM/INT_NUM/TIMEOUT_W constants.
- One sub-module, dispatch_watchdog: TIMEOUT_W counter with clear, enable, limit compare, and expire output. Everything else is inline.

## Test plan
- Reset, then start with int_num_in=5, core_en=4'b1111; pulse core_done 0,1,2,3 on separate cycles → core_start=1111 for one cycle at N+1, core_int_num=5, finish one cycle after core3's done, done_mask=1111, timed_out=0.
- core_en=4'b0101, timeout_limit=0; pulse core_done=1010 then 0101 → first pulse ignored; finish after second pulse, done_mask=0101.
- core_en=1111, timeout_limit=10, only cores 0 and 1 finish → finish 10 cycles after WAIT entry, timed_out=1, done_mask=0011. A variant with last done on the expiry cycle → timed_out=0.
- While busy, issue start (int 2, en 0001) then another start → first is queued, second gives overrun pulse. After the first finish, LAUNCH occurs in the next cycle with core_int_num=2 and core_start=0001.
- start with core_en=0 → finish on the next cycle, done_mask=0, core_start stays 0.
- Assert reset_n low during WAIT with pending full → all outputs 0 immediately. After release, no finish and no launch occur until a new start.
